apb_spi_master_fifo_if: RTL and testbench
=========================================

# apb_spi_master_fifo_if

Parametrised APB register interface for the SPI master core, successor to the single-entry register interface. Adds internal TX and RX FIFOs of configurable depth, a configurable chip-select count, and non-blocking APB access with error responses. Adds a maskable interrupt with level thresholds and sticky error flags. Sits between the APB interconnect and the SPI controller/clock-divider core.

## Interface
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave)
- NUM_CS, 4, chip-select lines (1..8)
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥2)
- HCLK  in  1  clock; one clock, all logic on rising edge
- HRESET  in  1  reset, asynchronous, active-high
- PADDR  in  APB_ADDR_WIDTH  register select uses PADDR[5:2]
- PWDATA  in  32  write data
- PWRITE, PSEL, PENABLE  in  1 each  APB control
- PRDATA  out  32  read data, combinational
- PREADY  out  1  tied 1; accesses never stall
- PSLVERR  out  1  error, combinational
- spi_clk_div  out  8, spi_clk_div_valid  out  1  divider and 1-cycle load pulse
- spi_status  in  32  core status
- spi_eot  in  1  end-of-transfer pulse from core
- spi_cmd, spi_addr  out  32 each
- spi_cmd_len, spi_addr_len  out  6 each
- spi_data_len, spi_dummy_rd, spi_dummy_wr  out  16 each
- spi_csreg  out  NUM_CS  chip-select enable
- spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst  out  1 each  1-cycle start/reset pulses
- spi_data_tx  out  32, spi_data_tx_valid  out  1, spi_data_tx_ready  in  1  TX stream to core
- spi_data_rx  in  32, spi_data_rx_valid  in  1, spi_data_rx_ready  out  1  RX stream from core
- irq  out  1  level interrupt

## Operation
- Access = PSEL&PENABLE; write = access&PWRITE, read = access&~PWRITE. Word offsets:
- 0 STATUS: W bit0 rd, 1 wr, 2 qrd, 3 qwr, 4 swrst (pulses); bits[8+NUM_CS-1:8] → spi_csreg. R: spi_status.
- 1 CLKDIV [7:0], write pulses spi_clk_div_valid. 2 SPICMD. 3 SPIADR.
- 4 SPILEN {data_len[31:16], addr_len[13:8], cmd_len[5:0]}. 5 SPIDUM {dummy_wr[31:16], dummy_rd[15:0]}.
- 6 TXFIFO W push. 7 RXFIFO R pop.
- 8 INTCFG: [4:0] enable mask, [15:8] tx_thr, [23:16] rx_thr.
- 9 INTSTAT: W1C sticky bits: [0] tx_low, [1] rx_high, [2] eot, [3] tx_ovf, [4] rx_udf.
- 10 FIFOSTAT R: [7:0] tx level, [23:16] rx level.
- Other offsets: read 0, write ignored, PSLVERR 0.
- Unwritten PWDATA/PRDATA bits: ignored on write, read 0.
- TX FIFO:
  - Push on TXFIFO write when not full.
  - Write when full: data dropped, PSLVERR=1, tx_ovf set.
  - spi_data_tx = head; spi_data_tx_valid = level≠0; pop on valid&ready.
- RX FIFO:
  - spi_data_rx_ready = level<RX_DEPTH; push on valid&ready.
  - RXFIFO read pops head (PRDATA = head).
  - Read when empty: PRDATA=0, PSLVERR=1, rx_udf set.
- Levels are clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH. Simultaneous push and pop on the same FIFO: level unchanged, both data moves occur (including when full or empty-with-bypass excluded: an empty FIFO cannot pop).
- Sticky set each cycle the condition holds:
  - tx_low: tx level ≤ tx_thr.
  - rx_high: rx level ≥ rx_thr and rx level≠0.
  - eot: spi_eot.
- Set wins over a W1C clear in the same cycle.
- irq = |(INTSTAT & mask), registered.
- swrst write: both FIFOs flushed (levels and pointers 0) at the same edge the pulse is issued. Flush overrides any simultaneous push or pop. Configuration registers and INTSTAT are retained.

## Timing
- Reset, asynchronous:
  - All registers 0; FIFOs empty; INTSTAT 0.
  - irq=0, all pulses 0, spi_data_tx_valid=0, spi_data_rx_ready=1, PSLVERR=0, PREADY=1.
- Config writes take effect at the access-cycle edge; outputs update the next cycle.
- Pulses are high exactly one cycle after the write edge, then self-clear. Back-to-back writes give back-to-back pulses.
- TX write in cycle n → spi_data_tx_valid high in n+1.
- RX push at edge n → readable (FIFOSTAT, RXFIFO) from cycle n+1.
- irq asserts 2 cycles after a source event: sticky set at edge, irq registered next edge.
- Reset mid-transfer drops FIFO contents with no pulse output.

## Test plan
- Reset → FIFOSTAT=0, INTSTAT=0, irq=0, rx_ready=1, tx_valid=0. Write SPILEN 0x0010_0820, read back → 0x0010_0820; spi_cmd_len=0x20, addr_len=0x08, data_len=0x0010.
- tx_ready=0, 9 TXFIFO writes of 1..9 (depth 8) → 9th gets PSLVERR=1, tx_ovf=1, level 8. Raise ready → core receives 1..8 in order.
- Core pushes 8 RX words while no reads → rx_ready drops after 8th. 9 RXFIFO reads → 8 words in order, 9th PSLVERR=1, PRDATA=0, rx_udf=1.
- INTCFG mask=0x04; spi_eot pulse → irq high 2 cycles later. W1C 0x04 to INTSTAT → irq low next cycle. Clear coincident with new eot → bit stays 1.
- TX level 3, write STATUS=0x10 with tx_ready=1 in the same cycle → spi_swrst pulse 1 cycle, FIFOSTAT=0, no extra TX pops after flush.
- Full TX, pop and push in the same cycle → level stays 8, no PSLVERR, order preserved.

Source files
------------

// File: rtl/apb_spi_master_fifo_if.sv
// APB register interface for the SPI master core with TX/RX FIFOs, chip-select
// register, sticky interrupt status and error responses on FIFO over/underflow.

module apb_spi_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]           level_q, level_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Flush wins over any push/pop issued in the same cycle
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;
endmodule

module apb_spi_master_fifo_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_CS         = 4,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [7:0]                spi_clk_div,
    output logic                      spi_clk_div_valid,
    input  logic [31:0]               spi_status,
    input  logic                      spi_eot,
    output logic [31:0]               spi_cmd,
    output logic [31:0]               spi_addr,
    output logic [5:0]                spi_cmd_len,
    output logic [5:0]                spi_addr_len,
    output logic [15:0]               spi_data_len,
    output logic [15:0]               spi_dummy_rd,
    output logic [15:0]               spi_dummy_wr,
    output logic [NUM_CS-1:0]         spi_csreg,
    output logic                      spi_rd,
    output logic                      spi_wr,
    output logic                      spi_qrd,
    output logic                      spi_qwr,
    output logic                      spi_swrst,
    output logic [31:0]               spi_data_tx,
    output logic                      spi_data_tx_valid,
    input  logic                      spi_data_tx_ready,
    input  logic [31:0]               spi_data_rx,
    input  logic                      spi_data_rx_valid,
    output logic                      spi_data_rx_ready,
    output logic                      irq
);
    localparam int TLW = $clog2(TX_DEPTH) + 1;
    localparam int RLW = $clog2(RX_DEPTH) + 1;

    localparam logic [3:0] R_STATUS   = 4'd0;
    localparam logic [3:0] R_CLKDIV   = 4'd1;
    localparam logic [3:0] R_SPICMD   = 4'd2;
    localparam logic [3:0] R_SPIADR   = 4'd3;
    localparam logic [3:0] R_SPILEN   = 4'd4;
    localparam logic [3:0] R_SPIDUM   = 4'd5;
    localparam logic [3:0] R_TXFIFO   = 4'd6;
    localparam logic [3:0] R_RXFIFO   = 4'd7;
    localparam logic [3:0] R_INTCFG   = 4'd8;
    localparam logic [3:0] R_INTSTAT  = 4'd9;
    localparam logic [3:0] R_FIFOSTAT = 4'd10;

    typedef struct packed {
        logic [7:0]        clk_div;
        logic [31:0]       cmd;
        logic [31:0]       addr;
        logic [15:0]       data_len;
        logic [5:0]        addr_len;
        logic [5:0]        cmd_len;
        logic [15:0]       dummy_wr;
        logic [15:0]       dummy_rd;
        logic [NUM_CS-1:0] csreg;
        logic [4:0]        int_en;
        logic [7:0]        tx_thr;
        logic [7:0]        rx_thr;
    } cfg_t;

    cfg_t       cfg_q, cfg_d;
    logic [4:0] pls_q, pls_d;          // {swrst, qwr, qrd, wr, rd}
    logic       clkdiv_vld_q, clkdiv_vld_d;
    logic [4:0] int_stat_q, int_stat_d;
    logic       irq_q, irq_d;

    logic [3:0] reg_sel;
    logic       acc, wr, rd;
    logic       tx_push, tx_pop, tx_full, tx_ovf_ev;
    logic       rx_push, rx_pop, rx_empty, rx_udf_ev, rx_rdy;
    logic       flush;
    logic [TLW-1:0] tx_level;
    logic [RLW-1:0] rx_level;
    logic [31:0]    tx_head, rx_head;
    logic [4:0]     int_set;
    logic           unused_paddr;

    assign reg_sel = PADDR[5:2];
    assign acc     = PSEL & PENABLE;
    assign wr      = acc & PWRITE;
    assign rd      = acc & ~PWRITE;
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

    // A write to a full TX FIFO is accepted if the core drains an entry in the same cycle
    assign tx_pop    = (tx_level != '0) & spi_data_tx_ready;
    assign tx_full   = tx_level == TLW'(TX_DEPTH);
    assign tx_ovf_ev = wr & (reg_sel == R_TXFIFO) & tx_full & ~tx_pop;
    assign tx_push   = wr & (reg_sel == R_TXFIFO) & ~tx_ovf_ev;

    assign rx_rdy    = rx_level != RLW'(RX_DEPTH);
    assign rx_push   = spi_data_rx_valid & rx_rdy;
    assign rx_empty  = rx_level == '0;
    assign rx_udf_ev = rd & (reg_sel == R_RXFIFO) & rx_empty;
    assign rx_pop    = rd & (reg_sel == R_RXFIFO) & ~rx_empty;

    assign flush = wr & (reg_sel == R_STATUS) & PWDATA[4];

    apb_spi_fifo #(.DEPTH(TX_DEPTH), .W(32)) u_tx_fifo (
        .clk(HCLK), .rst(HRESET), .push(tx_push), .pop(tx_pop), .flush(flush),
        .wdata(PWDATA), .rdata(tx_head), .level(tx_level)
    );

    apb_spi_fifo #(.DEPTH(RX_DEPTH), .W(32)) u_rx_fifo (
        .clk(HCLK), .rst(HRESET), .push(rx_push), .pop(rx_pop), .flush(flush),
        .wdata(spi_data_rx), .rdata(rx_head), .level(rx_level)
    );

    always_comb begin
        cfg_d        = cfg_q;
        pls_d        = '0;
        clkdiv_vld_d = 1'b0;
        if (wr) begin
            case (reg_sel)
                R_STATUS: begin
                    pls_d       = PWDATA[4:0];
                    cfg_d.csreg = PWDATA[8 +: NUM_CS];
                end
                R_CLKDIV: begin
                    cfg_d.clk_div = PWDATA[7:0];
                    clkdiv_vld_d  = 1'b1;
                end
                R_SPICMD: cfg_d.cmd = PWDATA;
                R_SPIADR: cfg_d.addr = PWDATA;
                R_SPILEN: begin
                    cfg_d.data_len = PWDATA[31:16];
                    cfg_d.addr_len = PWDATA[13:8];
                    cfg_d.cmd_len  = PWDATA[5:0];
                end
                R_SPIDUM: begin
                    cfg_d.dummy_wr = PWDATA[31:16];
                    cfg_d.dummy_rd = PWDATA[15:0];
                end
                R_INTCFG: begin
                    cfg_d.int_en = PWDATA[4:0];
                    cfg_d.tx_thr = PWDATA[15:8];
                    cfg_d.rx_thr = PWDATA[23:16];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        int_set[0] = 32'(tx_level) <= 32'(cfg_q.tx_thr);
        int_set[1] = (32'(rx_level) >= 32'(cfg_q.rx_thr)) & ~rx_empty;
        int_set[2] = spi_eot;
        int_set[3] = tx_ovf_ev;
        int_set[4] = rx_udf_ev;
        int_stat_d = int_stat_q;
        if (wr && reg_sel == R_INTSTAT) int_stat_d = int_stat_q & ~PWDATA[4:0];
        // Set after clear so a new event survives a coincident W1C
        int_stat_d = int_stat_d | int_set;
        irq_d      = |(int_stat_q & cfg_q.int_en);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cfg_q        <= '0;
            pls_q        <= '0;
            clkdiv_vld_q <= 1'b0;
            int_stat_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            pls_q        <= pls_d;
            clkdiv_vld_q <= clkdiv_vld_d;
            int_stat_q   <= int_stat_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (reg_sel)
                R_STATUS:   PRDATA = spi_status;
                R_CLKDIV:   PRDATA = {24'd0, cfg_q.clk_div};
                R_SPICMD:   PRDATA = cfg_q.cmd;
                R_SPIADR:   PRDATA = cfg_q.addr;
                R_SPILEN:   PRDATA = {cfg_q.data_len, 2'b00, cfg_q.addr_len, 2'b00, cfg_q.cmd_len};
                R_SPIDUM:   PRDATA = {cfg_q.dummy_wr, cfg_q.dummy_rd};
                R_RXFIFO:   PRDATA = rx_empty ? 32'd0 : rx_head;
                R_INTCFG:   PRDATA = {8'd0, cfg_q.rx_thr, cfg_q.tx_thr, 3'd0, cfg_q.int_en};
                R_INTSTAT:  PRDATA = {27'd0, int_stat_q};
                R_FIFOSTAT: PRDATA = 32'(tx_level) | (32'(rx_level) << 16);
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY            = 1'b1;
    assign PSLVERR           = tx_ovf_ev | rx_udf_ev;
    assign spi_clk_div       = cfg_q.clk_div;
    assign spi_clk_div_valid = clkdiv_vld_q;
    assign spi_cmd           = cfg_q.cmd;
    assign spi_addr          = cfg_q.addr;
    assign spi_cmd_len       = cfg_q.cmd_len;
    assign spi_addr_len      = cfg_q.addr_len;
    assign spi_data_len      = cfg_q.data_len;
    assign spi_dummy_rd      = cfg_q.dummy_rd;
    assign spi_dummy_wr      = cfg_q.dummy_wr;
    assign spi_csreg         = cfg_q.csreg;
    assign spi_rd            = pls_q[0];
    assign spi_wr            = pls_q[1];
    assign spi_qrd           = pls_q[2];
    assign spi_qwr           = pls_q[3];
    assign spi_swrst         = pls_q[4];
    assign spi_data_tx       = tx_head;
    assign spi_data_tx_valid = tx_level != '0;
    assign spi_data_rx_ready = rx_rdy;
    assign irq               = irq_q;
endmodule

// File: tb/tb_apb_spi_master_fifo_if.sv
// Directed bench for apb_spi_master_fifo_if: registers, FIFO flow/errors, interrupts, flush.

module tb_apb_spi_master_fifo_if;
    localparam logic [11:0] A_STATUS   = 12'h00;
    localparam logic [11:0] A_CLKDIV   = 12'h04;
    localparam logic [11:0] A_SPILEN   = 12'h10;
    localparam logic [11:0] A_TXFIFO   = 12'h18;
    localparam logic [11:0] A_RXFIFO   = 12'h1C;
    localparam logic [11:0] A_INTCFG   = 12'h20;
    localparam logic [11:0] A_INTSTAT  = 12'h24;
    localparam logic [11:0] A_FIFOSTAT = 12'h28;
    localparam logic [11:0] A_UNMAPPED = 12'h30;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  spi_clk_div;
    logic        spi_clk_div_valid;
    logic [31:0] spi_status = 32'hCAFE_0001;
    logic        spi_eot = 1'b0;
    logic [31:0] spi_cmd, spi_addr;
    logic [5:0]  spi_cmd_len, spi_addr_len;
    logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
    logic [3:0]  spi_csreg;
    logic        spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
    logic [31:0] spi_data_tx;
    logic        spi_data_tx_valid;
    logic        spi_data_tx_ready = 1'b0;
    logic [31:0] spi_data_rx = '0;
    logic        spi_data_rx_valid = 1'b0;
    logic        spi_data_rx_ready;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    apb_spi_master_fifo_if #(.APB_ADDR_WIDTH(12), .NUM_CS(4), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .spi_clk_div(spi_clk_div), .spi_clk_div_valid(spi_clk_div_valid),
        .spi_status(spi_status), .spi_eot(spi_eot), .spi_cmd(spi_cmd), .spi_addr(spi_addr),
        .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len),
        .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr), .spi_csreg(spi_csreg),
        .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr),
        .spi_swrst(spi_swrst), .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
        .spi_data_tx_ready(spi_data_tx_ready), .spi_data_rx(spi_data_rx),
        .spi_data_rx_valid(spi_data_rx_valid), .spi_data_rx_ready(spi_data_rx_ready), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    // Setup + access phase; txr/eot are driven only during the access cycle.
    // Returns one tick after the access edge, i.e. in the cycle where pulses are visible.
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic txr,
                          input logic eot, output logic err);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1; spi_data_tx_ready = txr; spi_eot = eot;
        @(negedge HCLK); err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; spi_data_tx_ready = 1'b0; spi_eot = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        @(negedge HCLK); d = PRDATA; err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rdat;
    logic        err;

    initial begin
        // Reset state, observed while reset is still held
        repeat (2) @(posedge HCLK);
        #1;
        PADDR = A_FIFOSTAT; PSEL = 1'b1; PENABLE = 1'b1;
        #1;
        chk("rst_fifostat", PRDATA, 32'h0);
        chk("rst_slverr", {31'd0, PSLVERR}, 32'd0);
        PADDR = A_INTSTAT;
        #1;
        chk("rst_intstat", PRDATA, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rx_ready", {31'd0, spi_data_rx_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, spi_data_tx_valid}, 32'd0);
        chk("rst_pready", {31'd0, PREADY}, 32'd1);
        chk("rst_pulses", {26'd0, spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst, spi_clk_div_valid}, 32'd0);
        tick();
        HRESET = 1'b0;
        tick();

        // Config registers
        apb_wr(A_SPILEN, 32'h0010_0820, 1'b0, 1'b0, err);
        apb_rd(A_SPILEN, rdat, err);
        chk("spilen_rb", rdat, 32'h0010_0820);
        chk("cmd_len", {26'd0, spi_cmd_len}, 32'h20);
        chk("addr_len", {26'd0, spi_addr_len}, 32'h08);
        chk("data_len", {16'd0, spi_data_len}, 32'h0010);

        apb_wr(A_CLKDIV, 32'h0000_005A, 1'b0, 1'b0, err);
        @(negedge HCLK);
        chk("clkdiv_vld_hi", {31'd0, spi_clk_div_valid}, 32'd1);
        chk("clkdiv_val", {24'd0, spi_clk_div}, 32'h5A);
        tick();
        @(negedge HCLK);
        chk("clkdiv_vld_lo", {31'd0, spi_clk_div_valid}, 32'd0);
        tick();

        apb_wr(A_STATUS, 32'h0000_0301, 1'b0, 1'b0, err);
        @(negedge HCLK);
        chk("rd_pulse_hi", {31'd0, spi_rd}, 32'd1);
        chk("csreg", {28'd0, spi_csreg}, 32'h3);
        tick();
        @(negedge HCLK);
        chk("rd_pulse_lo", {31'd0, spi_rd}, 32'd0);
        tick();

        apb_rd(A_STATUS, rdat, err);
        chk("status_rd", rdat, 32'hCAFE_0001);
        apb_rd(A_UNMAPPED, rdat, err);
        chk("unmapped_rd", rdat, 32'h0);
        chk("unmapped_err", {31'd0, err}, 32'd0);

        // TX overflow: 9 writes into a depth-8 FIFO with the core stalled
        for (int i = 1; i <= 9; i++) begin
            apb_wr(A_TXFIFO, 32'(i), 1'b0, 1'b0, err);
            chk($sformatf("tx_wr%0d_err", i), {31'd0, err}, (i == 9) ? 32'd1 : 32'd0);
        end
        chk("tx_valid_full", {31'd0, spi_data_tx_valid}, 32'd1);
        apb_rd(A_FIFOSTAT, rdat, err);
        chk("tx_level_full", rdat & 32'hFF, 32'd8);
        apb_rd(A_INTSTAT, rdat, err);
        chk("tx_ovf_flag", rdat & 32'h8, 32'h8);
        spi_data_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge HCLK);
            chk($sformatf("tx_drain%0d", i), spi_data_tx, 32'(i));
            tick();
        end
        @(negedge HCLK);
        chk("tx_empty", {31'd0, spi_data_tx_valid}, 32'd0);
        tick();
        spi_data_tx_ready = 1'b0;

        // Full TX FIFO with push and pop in the same cycle
        for (int i = 10; i <= 17; i++) apb_wr(A_TXFIFO, 32'(i), 1'b0, 1'b0, err);
        apb_wr(A_TXFIFO, 32'd18, 1'b1, 1'b0, err);
        chk("tx_pushpop_err", {31'd0, err}, 32'd0);
        apb_rd(A_FIFOSTAT, rdat, err);
        chk("tx_pushpop_lvl", rdat & 32'hFF, 32'd8);
        spi_data_tx_ready = 1'b1;
        for (int i = 11; i <= 18; i++) begin
            @(negedge HCLK);
            chk($sformatf("tx_pp_drain%0d", i), spi_data_tx, 32'(i));
            tick();
        end
        spi_data_tx_ready = 1'b0;

        // Soft reset flushes the TX FIFO despite a coincident pop
        for (int i = 0; i < 3; i++) apb_wr(A_TXFIFO, 32'h100 + 32'(i), 1'b0, 1'b0, err);
        apb_wr(A_STATUS, 32'h0000_0010, 1'b1, 1'b0, err);
        @(negedge HCLK);
        chk("swrst_hi", {31'd0, spi_swrst}, 32'd1);
        chk("swrst_tx_valid", {31'd0, spi_data_tx_valid}, 32'd0);
        tick();
        @(negedge HCLK);
        chk("swrst_lo", {31'd0, spi_swrst}, 32'd0);
        tick();
        apb_rd(A_FIFOSTAT, rdat, err);
        chk("swrst_fifostat", rdat, 32'h0);

        // RX fill until backpressure, then drain and underflow
        for (int i = 0; i < 8; i++) begin
            spi_data_rx_valid = 1'b1; spi_data_rx = 32'hA0 + 32'(i);
            @(negedge HCLK);
            chk($sformatf("rx_ready%0d", i), {31'd0, spi_data_rx_ready}, 32'd1);
            tick();
        end
        spi_data_rx_valid = 1'b0;
        @(negedge HCLK);
        chk("rx_full_ready", {31'd0, spi_data_rx_ready}, 32'd0);
        tick();
        apb_rd(A_FIFOSTAT, rdat, err);
        chk("rx_level_full", rdat, 32'h0008_0000);
        for (int i = 0; i < 9; i++) begin
            apb_rd(A_RXFIFO, rdat, err);
            chk($sformatf("rx_rd%0d", i), rdat, (i == 8) ? 32'h0 : 32'hA0 + 32'(i));
            chk($sformatf("rx_rd%0d_err", i), {31'd0, err}, (i == 8) ? 32'd1 : 32'd0);
        end
        apb_rd(A_INTSTAT, rdat, err);
        chk("rx_udf_flag", rdat & 32'h10, 32'h10);
        chk("rx_ready_again", {31'd0, spi_data_rx_ready}, 32'd1);

        // Interrupt: eot source, W1C, and set-beats-clear
        apb_wr(A_INTCFG, 32'h0000_0004, 1'b0, 1'b0, err);
        apb_wr(A_INTSTAT, 32'h0000_001F, 1'b0, 1'b0, err);
        tick();
        spi_eot = 1'b1;
        @(negedge HCLK);
        chk("irq_n0", {31'd0, irq}, 32'd0);
        tick();
        spi_eot = 1'b0;
        @(negedge HCLK);
        chk("irq_n1", {31'd0, irq}, 32'd0);
        tick();
        @(negedge HCLK);
        chk("irq_n2", {31'd0, irq}, 32'd1);
        tick();
        apb_wr(A_INTSTAT, 32'h0000_0004, 1'b0, 1'b0, err);
        tick();
        @(negedge HCLK);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        tick();
        apb_wr(A_INTSTAT, 32'h0000_0004, 1'b0, 1'b1, err);
        apb_rd(A_INTSTAT, rdat, err);
        chk("eot_set_wins", rdat & 32'h4, 32'h4);
        @(negedge HCLK);
        chk("irq_after_setwin", {31'd0, irq}, 32'd1);
        tick();

        // Asynchronous reset mid-transfer drops TX contents
        apb_wr(A_TXFIFO, 32'h55, 1'b0, 1'b0, err);
        #2 HRESET = 1'b1;
        #1;
        chk("midrst_tx_valid", {31'd0, spi_data_tx_valid}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        tick();
        HRESET = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
